// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and widths for the unified-memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_AW = 30;
  localparam int WORD_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // The requester that did not take the previous grant
  function automatic owner_t other_owner(input owner_t i_own);
    return (i_own == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Purpose  : Combinational winner select between fetch and data requests,
//             either fixed data priority or round-robin on the last grant.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int PRIO_DATA = 1
) (
  input  logic   i_if_req,
  input  logic   i_d_req,
  input  owner_t i_last_grant,
  output logic   o_any,
  output owner_t o_winner
);

  // Pick the winner; only a real conflict consults the last grant
  always_comb begin
    o_any    = i_if_req | i_d_req;
    o_winner = OWN_IF;
    if (PRIO_DATA != 0) begin
      if (i_d_req) begin
        o_winner = OWN_D;
      end
    end else if (i_if_req && i_d_req) begin
      o_winner = other_owner(i_last_grant);
    end else if (i_d_req) begin
      o_winner = OWN_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported word memory between instruction fetch
//             and data load/store. One transaction at a time:
//             IDLE (grant) -> ACCESS -> WAIT (RD_LAT-1) -> RESP -> IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LAT    = 1,  // 1..4
  parameter int PRIO_DATA = 1
) (
  input  logic               clk,
  input  logic               rst,
  // instruction fetch port
  input  logic               i_if_req,
  input  logic [WORD_AW-1:0] i_if_addr,
  output logic               o_if_gnt,
  output logic               o_if_rvalid,
  output logic [WORD_DW-1:0] o_if_rdata,
  // data load/store port
  input  logic               i_d_req,
  input  logic               i_d_we,
  input  logic [WORD_AW-1:0] i_d_addr,
  input  logic [WORD_DW-1:0] i_d_wdata,
  output logic               o_d_gnt,
  output logic               o_d_rvalid,
  output logic [WORD_DW-1:0] o_d_rdata,
  // memory side
  output logic [WORD_AW-1:0] o_mem_addr,
  output logic [WORD_DW-1:0] o_mem_wdata,
  output logic               o_mem_wren,
  input  logic [WORD_DW-1:0] i_mem_rdata,
  output logic               o_busy
);

  // Number of WAIT cycles between ACCESS and RESP
  localparam logic [1:0] c_wait_cycles = 2'(RD_LAT - 1);

  arb_state_t         r_state;
  owner_t             r_owner;      // owner of the current/last grant (= last_grant)
  logic               r_we;
  logic [1:0]         r_cnt;
  logic [WORD_AW-1:0] r_mem_addr;
  logic [WORD_DW-1:0] r_mem_wdata;
  logic               r_mem_wren;
  logic               r_if_rvalid;
  logic               r_d_rvalid;
  logic               r_busy;
  logic [WORD_DW-1:0] r_if_rdata;
  logic [WORD_DW-1:0] r_d_rdata;

  logic               w_any;
  owner_t             w_winner;
  logic               w_grant;
  logic [WORD_DW-1:0] w_d_resp_data;

  mem_arb_pick #(
    .PRIO_DATA (PRIO_DATA)
  ) u_pick (
    .i_if_req     (i_if_req),
    .i_d_req      (i_d_req),
    .i_last_grant (r_owner),
    .o_any        (w_any),
    .o_winner     (w_winner)
  );

  // Grants are only issued from IDLE and are suppressed while reset is held
  assign w_grant  = (r_state == IDLE) && w_any && !rst;
  assign o_if_gnt = w_grant && (w_winner == OWN_IF);
  assign o_d_gnt  = w_grant && (w_winner == OWN_D);

  // A store returns the value it wrote rather than whatever the memory drives
  assign w_d_resp_data = r_we ? r_mem_wdata : i_mem_rdata;

  // Memory data is valid only in the response cycle, so it is forwarded then
  // and held in the rdata registers afterwards
  assign o_if_rdata  = r_if_rvalid ? i_mem_rdata   : r_if_rdata;
  assign o_d_rdata   = r_d_rvalid  ? w_d_resp_data : r_d_rdata;
  assign o_if_rvalid = r_if_rvalid;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wren  = r_mem_wren;
  assign o_busy      = r_busy;

  // Transaction FSM with latency counter, request latch and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_D;       // so fetch wins the first round-robin conflict
      r_we        <= 1'b0;
      r_cnt       <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wren  <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_busy      <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_mem_wren  <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_busy  <= 1'b1;
            r_state <= ACCESS;
            if (w_winner == OWN_D) begin
              r_mem_addr  <= i_d_addr;
              r_mem_wdata <= i_d_wdata;
              r_we        <= i_d_we;
              r_mem_wren  <= i_d_we;  // high for the ACCESS cycle only
            end else begin
              r_mem_addr  <= i_if_addr;
              r_we        <= 1'b0;    // fetch never writes
            end
          end
        end
        ACCESS: begin
          r_cnt <= c_wait_cycles;
          if (c_wait_cycles == 2'd0) begin
            r_state     <= RESP;
            r_if_rvalid <= (r_owner == OWN_IF);
            r_d_rvalid  <= (r_owner == OWN_D);
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_state     <= RESP;
            r_if_rvalid <= (r_owner == OWN_IF);
            r_d_rvalid  <= (r_owner == OWN_D);
          end
        end
        RESP: begin
          if (r_owner == OWN_D) begin
            r_d_rdata <= w_d_resp_data;
          end else begin
            r_if_rdata <= i_mem_rdata;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench. Instance A: RD_LAT=1, data priority.
//             Instance B: RD_LAT=3, round-robin. A transaction-schedule model
//             predicts every output each cycle; directed cases pin it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req    [2];
  logic [29:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [29:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_gnt     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic [29:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_wren  [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.RD_LAT(1), .PRIO_DATA(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .i_if_req(if_req[0]), .i_if_addr(if_addr[0]), .o_if_gnt(if_gnt[0]),
    .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
    .i_d_req(d_req[0]), .i_d_we(d_we[0]), .i_d_addr(d_addr[0]), .i_d_wdata(d_wdata[0]),
    .o_d_gnt(d_gnt[0]), .o_d_rvalid(d_rvalid[0]), .o_d_rdata(d_rdata[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .o_mem_wren(mem_wren[0]),
    .i_mem_rdata(mem_rdata[0]), .o_busy(busy[0])
  );

  mem_port_arbiter #(.RD_LAT(3), .PRIO_DATA(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_if_req(if_req[1]), .i_if_addr(if_addr[1]), .o_if_gnt(if_gnt[1]),
    .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
    .i_d_req(d_req[1]), .i_d_we(d_we[1]), .i_d_addr(d_addr[1]), .i_d_wdata(d_wdata[1]),
    .o_d_gnt(d_gnt[1]), .o_d_rvalid(d_rvalid[1]), .o_d_rdata(d_rdata[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .o_mem_wren(mem_wren[1]),
    .i_mem_rdata(mem_rdata[1]), .o_busy(busy[1])
  );

  // ---------------- memory environment (key = {instance, word address}) ---
  logic [31:0] emem [logic [30:0]];
  logic [31:0] rmem [logic [30:0]];
  logic [31:0] pipe [2][4];

  function automatic logic [31:0] seed(input logic [30:0] key);
    return ({1'b0, key} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] env_rd(input logic [30:0] key);
    return emem.exists(key) ? emem[key] : seed(key);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [30:0] key);
    return rmem.exists(key) ? rmem[key] : seed(key);
  endfunction

  // Memory samples the registered address each edge; data emerges RD_LAT later
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) pipe[k][s] <= pipe[k][s-1];
      pipe[k][0] <= env_rd({k[0], mem_addr[k]});
      if (mem_wren[k] === 1'b1) emem[{k[0], mem_addr[k]}] = mem_wdata[k];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // ---------------- reference model and checking ---------------------------
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          tg      [2];
  int          free_at [2];
  bit          act     [2];
  bit          last_d  [2];
  bit          t_d     [2];
  bit          t_we    [2];
  logic [29:0] t_addr  [2];
  logic [29:0] e_addr  [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rdata [2];
  logic [31:0] e_ifr   [2];
  logic [31:0] e_dr    [2];
  bit          seen_if [2];
  bit          seen_d  [2];

  task automatic chk(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL [%0d] %s at cycle %0d: got %h, expected %h", k, nm, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int k);
    int lat;
    bit prio, win_d, e_busy, e_wren, e_rvi, e_rvd, e_gi, e_gd;
    lat  = (k == 0) ? 1 : 3;
    prio = (k == 0);
    if (rst) begin
      chk(k, "rst_if_gnt", if_gnt[k], 0);     chk(k, "rst_d_gnt", d_gnt[k], 0);
      chk(k, "rst_if_rvalid", if_rvalid[k], 0); chk(k, "rst_d_rvalid", d_rvalid[k], 0);
      chk(k, "rst_wren", mem_wren[k], 0);     chk(k, "rst_busy", busy[k], 0);
      chk(k, "rst_mem_addr", mem_addr[k], 0); chk(k, "rst_if_rdata", if_rdata[k], 0);
      chk(k, "rst_d_rdata", d_rdata[k], 0);
      act[k] = 0; free_at[k] = 0; last_d[k] = 1;
      e_addr[k] = '0; e_ifr[k] = '0; e_dr[k] = '0;
      seen_if[k] = 0; seen_d[k] = 0;
      return;
    end
    // outputs owed by the transaction already in flight
    e_busy = act[k] && (cyc >= tg[k] + 1) && (cyc <= tg[k] + 1 + lat);
    e_wren = act[k] && (cyc == tg[k] + 1) && t_we[k];
    e_rvi  = act[k] && (cyc == tg[k] + 1 + lat) && !t_d[k];
    e_rvd  = act[k] && (cyc == tg[k] + 1 + lat) && t_d[k];
    if (e_rvi) e_ifr[k] = t_rdata[k];
    if (e_rvd) e_dr[k]  = t_rdata[k];
    chk(k, "mem_wren", mem_wren[k], {31'd0, e_wren});
    if (e_wren) begin
      chk(k, "mem_wdata", mem_wdata[k], t_wdata[k]);
      rmem[{k[0], t_addr[k]}] = t_wdata[k];
    end
    chk(k, "busy", busy[k], {31'd0, e_busy});
    chk(k, "mem_addr", mem_addr[k], {2'b00, e_addr[k]});
    chk(k, "if_rvalid", if_rvalid[k], {31'd0, e_rvi});
    chk(k, "d_rvalid", d_rvalid[k], {31'd0, e_rvd});
    chk(k, "if_rdata", if_rdata[k], e_ifr[k]);
    chk(k, "d_rdata", d_rdata[k], e_dr[k]);
    // arbitration for this cycle
    e_gi = 0; e_gd = 0;
    if ((cyc >= free_at[k]) && (if_req[k] || d_req[k])) begin
      if (prio)                         win_d = d_req[k];
      else if (if_req[k] && d_req[k])   win_d = !last_d[k];
      else                              win_d = d_req[k];
      e_gi = !win_d; e_gd = win_d;
      act[k] = 1; tg[k] = cyc; free_at[k] = cyc + 2 + lat; last_d[k] = win_d;
      t_d[k] = win_d; t_we[k] = win_d && d_we[k];
      t_addr[k]  = win_d ? d_addr[k] : if_addr[k];
      t_wdata[k] = d_wdata[k];
      t_rdata[k] = t_we[k] ? d_wdata[k] : ref_rd({k[0], t_addr[k]});
    end
    chk(k, "if_gnt", if_gnt[k], {31'd0, e_gi});
    chk(k, "d_gnt", d_gnt[k], {31'd0, e_gd});
    if (e_gi || e_gd) e_addr[k] = t_addr[k];
    seen_if[k] = if_gnt[k];
    seen_d[k]  = d_gnt[k];
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
    cyc++;
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] pick_addr();
    case ($urandom_range(5))
      0:       return 30'h3;
      1:       return 30'h20;
      2:       return 30'h3FFFFFFF;
      3:       return 30'h0;
      4:       return 30'($urandom_range(15));
      default: return 30'($urandom);
    endcase
  endfunction

  task automatic drive_rand(input int k);
    if (if_req[k]) begin
      if (seen_if[k]) begin
        if ($urandom_range(1) == 0) if_addr[k] = pick_addr();
        else                        if_req[k]  = 1'b0;
      end else if ($urandom_range(15) == 0) begin
        if_req[k] = 1'b0;
      end
    end else if ($urandom_range(2) == 0) begin
      if_req[k] = 1'b1; if_addr[k] = pick_addr();
    end
    if (d_req[k]) begin
      if (seen_d[k]) begin
        if ($urandom_range(1) == 0) begin
          d_addr[k] = pick_addr(); d_we[k] = 1'($urandom_range(1)); d_wdata[k] = $urandom;
        end else begin
          d_req[k] = 1'b0;
        end
      end else if ($urandom_range(15) == 0) begin
        d_req[k] = 1'b0;
      end
    end else if ($urandom_range(2) == 0) begin
      d_req[k] = 1'b1; d_addr[k] = pick_addr();
      d_we[k] = 1'($urandom_range(1)); d_wdata[k] = $urandom;
    end
  endtask

  initial begin
    int nd, if_at, n;
    bit got_if;
    int seq [4];
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
    end
    emem[{1'b0, 30'h3}] = 32'h241b0000;
    rmem[{1'b0, 30'h3}] = 32'h241b0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: fetch of word 3 on A
    if_req[0] = 1; if_addr[0] = 30'h3;
    @(negedge clk); chk(0, "t1_if_gnt", if_gnt[0], 1);
    tick(); if_req[0] = 0;
    @(negedge clk); chk(0, "t1_wren", mem_wren[0], 0);
    @(negedge clk); chk(0, "t1_if_rvalid", if_rvalid[0], 1);
    chk(0, "t1_if_rdata", if_rdata[0], 32'h241b0000);

    // 2: store then load-back on A
    tick(); d_req[0] = 1; d_we[0] = 1; d_addr[0] = 30'h20; d_wdata[0] = 32'hDEADBEEF;
    @(negedge clk); chk(0, "t2_d_gnt", d_gnt[0], 1);
    tick(); d_req[0] = 0;
    @(negedge clk); chk(0, "t2_wren_hi", mem_wren[0], 1); chk(0, "t2_mem_addr", mem_addr[0], 32'h20);
    @(negedge clk); chk(0, "t2_wren_lo", mem_wren[0], 0); chk(0, "t2_d_rvalid", d_rvalid[0], 1);
    chk(0, "t2_d_rdata", d_rdata[0], 32'hDEADBEEF);
    tick(); d_req[0] = 1; d_we[0] = 0;
    @(negedge clk); chk(0, "t2_ld_gnt", d_gnt[0], 1);
    tick(); d_req[0] = 0;
    @(negedge clk);
    @(negedge clk); chk(0, "t2_ld_rvalid", d_rvalid[0], 1);
    chk(0, "t2_ld_rdata", d_rdata[0], 32'hDEADBEEF);

    // 3: data priority on A
    tick(); if_req[0] = 1; if_addr[0] = 30'h5; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 30'h7;
    nd = 0; if_at = -1; got_if = 0;
    for (int c = 0; c < 60 && !got_if; c++) begin
      @(negedge clk);
      if (d_gnt[0]) nd++;
      if (if_gnt[0]) begin if_at = nd; got_if = 1; end
      tick();
      if (nd >= 3) d_req[0] = 0;
    end
    if_req[0] = 0; d_req[0] = 0;
    chk(0, "t3_if_granted", {31'd0, got_if}, 1);
    chk(0, "t3_d_grants_before_if", if_at, 3);
    repeat (6) tick();

    // 4: round-robin on B
    if_req[1] = 1; if_addr[1] = 30'h9; d_req[1] = 1; d_we[1] = 0; d_addr[1] = 30'hA;
    n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (if_gnt[1])     begin seq[n] = 0; n++; end
      else if (d_gnt[1]) begin seq[n] = 1; n++; end
      tick();
    end
    if_req[1] = 0; d_req[1] = 0;
    chk(1, "t4_grant_count", n, 4);
    for (int i = 0; i < 4; i++) chk(1, $sformatf("t4_grant%0d_is_d", i), seq[i], i % 2);
    repeat (8) tick();

    // 5: RD_LAT=3 load on B with a fetch waiting
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 30'h3FFFFFFF;
    @(negedge clk); chk(1, "t5_d_gnt", d_gnt[1], 1);
    tick(); d_req[1] = 0; if_req[1] = 1; if_addr[1] = 30'h11;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk(1, $sformatf("t5_busy_n%0d", i), busy[1], 1);
      chk(1, $sformatf("t5_no_gnt_n%0d", i), if_gnt[1], 0);
      chk(1, $sformatf("t5_d_rvalid_n%0d", i), d_rvalid[1], (i == 4) ? 1 : 0);
      if (i == 1) chk(1, "t5_max_addr", mem_addr[1], 32'h3FFFFFFF);
    end
    @(negedge clk); chk(1, "t5_busy_off", busy[1], 0); chk(1, "t5_if_gnt_n5", if_gnt[1], 1);
    tick(); if_req[1] = 0;
    repeat (8) tick();

    // 6: reset during the ACCESS cycle of a store on A
    d_req[0] = 1; d_we[0] = 1; d_addr[0] = 30'h55; d_wdata[0] = 32'h12345678;
    @(negedge clk); chk(0, "t6_d_gnt", d_gnt[0], 1);
    tick(); d_req[0] = 0; rst = 1;
    #1; chk(0, "t6_wren_async", mem_wren[0], 0); chk(0, "t6_d_rvalid", d_rvalid[0], 0);
    @(negedge clk); tick();
    @(negedge clk); tick();
    rst = 0;
    if_req[0] = 1; if_addr[0] = 30'h6; d_req[0] = 1; d_we[0] = 0; d_addr[0] = 30'h55;
    if_req[1] = 1; d_req[1] = 1; d_we[1] = 0;
    @(negedge clk);
    chk(0, "t6_a_d_first", d_gnt[0], 1); chk(0, "t6_a_if_wait", if_gnt[0], 0);
    chk(1, "t6_b_if_first", if_gnt[1], 1); chk(1, "t6_b_d_wait", d_gnt[1], 0);
    tick();
    for (int k = 0; k < 2; k++) begin if_req[k] = 0; d_req[k] = 0; end
    @(negedge clk);
    @(negedge clk); chk(0, "t6_ld_rvalid", d_rvalid[0], 1);
    chk(0, "t6_store_lost", d_rdata[0], seed({1'b0, 30'h55}));
    repeat (8) tick();

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive_rand(0);
      drive_rand(1);
    end
    tick();
    for (int k = 0; k < 2; k++) begin if_req[k] = 0; d_req[k] = 0; end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
